// File: rtl/clickreg_pkg.sv
// rtl/clickreg_pkg.sv - record layout helpers shared by the click register and the record packer
// Purpose: one place that defines where each field sits in a time-stamped click
//          record, so the producer and the downstream packer cannot disagree.
// Contents:
//   TS_LSB          timestamp field LSB (always 0)
//   WRAP_BIT(t)     bit index of the timer-wrap flag for a t-bit timestamp
//   MASK_LSB(t)     LSB of the channel mask field for a t-bit timestamp
//   DATA_W(n, t)    total record width for n channels and a t-bit timestamp
//   DROP_W          width of the saturating dropped-record counter
package clickreg_pkg;

  localparam int TS_LSB = 0;
  localparam int DROP_W = 16;

  function automatic int WRAP_BIT(input int time_w);
    return time_w;
  endfunction

  function automatic int MASK_LSB(input int time_w);
    return time_w + 1;
  endfunction

  function automatic int DATA_W(input int n_chan, input int time_w);
    return n_chan + 1 + time_w;
  endfunction

endpackage

// File: rtl/clickreg_fifo.sv
// rtl/clickreg_fifo.sv - first-word-fall-through record buffer
// Purpose: DEPTH x WIDTH FWFT FIFO. The head entry is presented on data while
//          the FIFO is non-empty; when empty, data keeps the last popped entry.
//          Push and pop in the same cycle are both honoured, also when full.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset (empties the FIFO at once)
//   push       in   write push_data (ignored when full unless popping too)
//   push_data  in   WIDTH-bit entry to write
//   pop        in   remove the head entry (ignored when empty)
//   data       out  head entry, or last popped entry when empty
//   empty      out  no entries held
//   full       out  DEPTH entries held
module clickreg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hold;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign data = empty ? hold : mem[rd_ptr];

endmodule

// File: rtl/multiclickreg.sv
// rtl/multiclickreg.sv - multichannel click registration and time-stamping
// Purpose: rising-edge-detects N_CHAN detector levels, stamps each event (and
//          each timer wrap) with a free-running TIME_W-bit timer and buffers the
//          records in an FWFT FIFO drained by ready/ack. Counts dropped records.
// Optional feature: define CLICKREG_DEADTIME_EN for a per-channel holdoff of
//          DEAD_CYCLES cycles after each accepted edge.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   channel     in   synchronised detector levels
//   clear       in   synchronous timer / overflow statistics clear
//   operate     in   registration enable
//   data        out  head record {mask, wrap, timestamp}
//   ready       out  head record valid
//   ack         in   consumer takes the head record when ready && ack
//   overflow    out  sticky: a record was dropped
//   drop_count  out  saturating dropped-record count
module multiclickreg
  import clickreg_pkg::*;
#(
  parameter int N_CHAN      = 4,
  parameter int TIME_W      = 36,
  parameter int DEPTH       = 8,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_CHAN-1:0]                channel,
  input  logic                             clear,
  input  logic                             operate,
  output logic [DATA_W(N_CHAN, TIME_W)-1:0] data,
  output logic                             ready,
  input  logic                             ack,
  output logic                             overflow,
  output logic [DROP_W-1:0]                drop_count
);

  localparam int DW = DATA_W(N_CHAN, TIME_W);

  if (N_CHAN < 1 || N_CHAN > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEAD_CYCLES < 0)
  begin : g_param_check
    $error("multiclickreg: illegal parameter combination");
  end

  logic [TIME_W-1:0] timer;
  logic [N_CHAN-1:0] ch_q;
  logic [N_CHAN-1:0] rise;
  logic [N_CHAN-1:0] accepted;
  logic              wrap_now;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              drop;
  logic [DW-1:0]     record;

  assign rise     = channel & ~ch_q;
  assign wrap_now = (timer == '0);

`ifdef CLICKREG_DEADTIME_EN
  localparam int CNT_W = ($clog2(DEAD_CYCLES + 1) > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  logic [CNT_W-1:0]  dead_cnt [N_CHAN];
  logic [N_CHAN-1:0] busy;

  always_comb begin
    busy = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      busy[i] = (dead_cnt[i] != '0);
    end
  end

  assign accepted = rise & ~busy;

  // Holdoff runs regardless of operate: an edge passing the mask arms it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CHAN; i++) begin
        dead_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (accepted[i]) begin
          dead_cnt[i] <= CNT_W'(DEAD_CYCLES);
        end else if (busy[i]) begin
          dead_cnt[i] <= dead_cnt[i] - CNT_W'(1);
        end
      end
    end
  end
`else
  assign accepted = rise;
`endif

  // A pure wrap marker carries an all-zero mask.
  assign push = operate && ((accepted != '0) || wrap_now);
  assign pop  = ready && ack;
  assign drop = push && full && !pop;

  always_comb begin
    record = '0;
    record[TS_LSB +: TIME_W]           = timer;
    record[WRAP_BIT(TIME_W)]           = wrap_now;
    record[MASK_LSB(TIME_W) +: N_CHAN] = accepted;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
      ch_q  <= '0;
    end else begin
      timer <= clear ? '0 : timer + TIME_W'(1);
      ch_q  <= channel;
    end
  end

  // clear outranks a drop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

  clickreg_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (record),
    .pop       (pop),
    .data      (data),
    .empty     (empty),
    .full      (full)
  );

  assign ready = !empty;

endmodule

// File: doc/multiclickreg.md
# multiclickreg

Parametrised multichannel pulse registration and time-stamping block: the successor to the fixed 4-channel click register. It rising-edge-detects N_CHAN detector inputs and stamps each event with a free-running TIME_W-bit timer. Each stamped record goes into a first-word-fall-through buffer drained over a valid/ready handshake. It sits between the input synchronisers and the record packer/USB FIFO. It adds buffering, timer-wrap markers, overflow accounting and optional per-channel dead time.

## Interface
Parameters:
- N_CHAN, 4, number of detector channels (1..16)
- TIME_W, 36, timestamp width
- DEPTH, 8, record buffer depth (power of 2, ≥2)
- DEAD_CYCLES, 4, per-channel holdoff after an accepted edge (used only with CLICKREG_DEADTIME_EN)

Ports:
- clk  in  1  system clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- channel  in  N_CHAN  synchronised detector levels
- clear  in  1  synchronous timer/statistics clear
- operate  in  1  registration enable
- data  out  N_CHAN+1+TIME_W  head record: [TIME_W-1:0] timestamp, [TIME_W] wrap flag, [top:TIME_W+1] channel mask
- ready  out  1  head record valid
- ack  in  1  consumer accepts head record when ready&&ack
- overflow  out  1  sticky: at least one record dropped
- drop_count  out  16  saturating count of dropped records

## Operation
- Reset values: timer=0, channel history=0, buffer empty, ready=0, data=0, overflow=0, drop_count=0, dead-time counters=0.
- Timer: each cycle timer <= clear ? 0 : timer+1, wrapping modulo 2^TIME_W.
- Edge detection: rise = channel & ~ch_q, where ch_q is channel registered last cycle. Only 0→1 transitions count. A level held high produces one event.
- Record generation is gated by operate. A record is pushed in cycle k if operate=1 and either (rise≠0) or (timer==0). In that record:
  - mask = rise (may be 0 for a pure wrap marker)
  - wrap = (timer==0)
  - timestamp = timer value during cycle k, before the increment
- Simultaneous edges on several channels produce one record with several mask bits.
- With operate=0, edges and wraps are discarded. Edge history is still updated.
- Buffer behaviour:
  - The head record is presented on data/ready.
  - Pop on ready&&ack.
  - Push and pop in the same cycle are both honoured, including when the buffer is full.
  - data holds its last value when the buffer is empty.
- Overflow: a push while full, with no pop, drops the new record. In that case overflow<=1 and drop_count increments, saturating at 16'hFFFF.
- clear in the same cycle clears overflow and drop_count, and resets the timer. A record generated in that cycle still uses the pre-clear timer value. Buffer contents are not flushed.

## Timing
- Edge visible on channel in cycle k → record at head, ready=1, in cycle k+1 when the buffer is empty (1-cycle latency).
- Back-to-back rises on one channel need a 0 cycle between them, so minimum event spacing is 2 cycles per channel.
- After clear asserts in cycle k, timer=0 in cycle k+1. With operate=1, that cycle emits a wrap record with timestamp 0.
- reset_n assertion mid-operation empties the buffer immediately (asynchronously); ready falls without waiting for a clock edge.
- ready never depends combinationally on ack.

## Configuration
- CLICKREG_DEADTIME_EN defined: each channel has a counter loaded with DEAD_CYCLES on an accepted edge.
  - Rises on that channel are masked while its counter is nonzero.
  - Example: an edge accepted at cycle k masks rises at k+1..k+DEAD_CYCLES; a rise at k+DEAD_CYCLES+1 is accepted.
  - Counters decrement every cycle, independent of operate.
- Undefined: no counters. Every rise is recorded, and DEAD_CYCLES is ignored.

## Structure
- clickreg_pkg: record field offset/width localparams or functions (TS_LSB, WRAP_BIT, MASK_LSB, DATA_W from N_CHAN/TIME_W) and the drop_count width, shared with the record packer.
- Sub-module clickreg_fifo: synchronous FWFT FIFO, DEPTH×DATA_W, with full/empty, same-cycle push/pop and async active-low reset.

## Test plan
- Reset, operate=1, clear pulse at cycle 0 → wrap record {mask=0, wrap=1, ts=0} with ready at cycle 2; ack → ready=0.
- channel=4'b0101 rising in the cycle the timer reads 100, held high → exactly one record {mask=0101, wrap=0, ts=100}, none while held.
- ack held low, 12 edges on ch0 spaced 2 cycles, DEPTH=8 → 8 records retained in order; overflow=1; drop_count=4. A clear then zeroes both, and the buffered records remain.
- Buffer full with push and ack in the same cycle → no drop; the new record appears at the tail; occupancy stays at 8.
- TIME_W=8, free run with operate=1 → wrap record with ts=0 every 256 cycles; an edge at timer 0 gives {mask=0001, wrap=1}.
- CLICKREG_DEADTIME_EN, DEAD_CYCLES=4, ch1 rises at k, k+2, k+6 → records at k and k+6 only. Without the macro: records at all three.
